// File: rtl/postfix_converter.sv
// Shunting-yard infix-to-postfix converter: reads the number builder's token array
// through a combinational read port and writes RPN tokens for the evaluator.
module postfix_converter #(
   parameter  int unsigned depth      = 20,
   parameter  int unsigned newWidth   = 42,
   parameter  int unsigned stackDepth = 16,
   localparam int unsigned aw         = $clog2(depth + 1)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic [aw-1:0]       inCount,
   output logic [aw-1:0]       inAddr,
   input  logic [newWidth-1:0] inData,
   output logic                outWe,
   output logic [aw-1:0]       outAddr,
   output logic [newWidth-1:0] outData,
   output logic [aw-1:0]       outCount,
   output logic                busy,
   output logic                done,
   output logic                error
);

   localparam int unsigned SPW = $clog2(stackDepth + 1);
   localparam int unsigned SIW = (stackDepth > 1) ? $clog2(stackDepth) : 1;

   localparam logic [7:0] C_ADD = 8'd10;
   localparam logic [7:0] C_SUB = 8'd11;
   localparam logic [7:0] C_MUL = 8'd12;
   localparam logic [7:0] C_DIV = 8'd13;
   localparam logic [7:0] C_LP  = 8'd14;
   localparam logic [7:0] C_RP  = 8'd15;
   localparam logic [7:0] C_POW = 8'd17;
   localparam logic [2:0] P_FN  = 3'd4;

   typedef enum logic [2:0] {S_IDLE, S_SCAN, S_FLUSH, S_DONE, S_ERR} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [newWidth-1:0] r_stack [stackDepth];
   logic [SPW-1:0]      r_sp;
   logic [aw-1:0]       r_idx;
   logic [aw-1:0]       r_count;
   logic                r_fn_pend;
   logic                r_we;
   logic [aw-1:0]       r_out_addr;
   logic [newWidth-1:0] r_out_data;
   logic [aw-1:0]       r_out_count;
   logic                r_busy;
   logic                r_done;
   logic                r_error;

   logic [SIW-1:0]      w_top_idx;
   logic [newWidth-1:0] w_top;
   logic [7:0]          w_top_code;
   logic [7:0]          w_in_code;
   logic [2:0]          w_top_prec;
   logic [2:0]          w_in_prec;
   logic                w_stack_empty;
   logic                w_stack_full;
   logic                w_start_acc;
   logic                w_push;
   logic                w_pop;
   logic                w_emit_in;
   logic                w_emit_top;
   logic                w_adv;
   logic                w_fn_set;

   // Binding strength; parentheses rank 0, anything unrecognised is a prefix function.
   function automatic logic [2:0] prec(input logic [7:0] c);
      case (c)
         C_ADD, C_SUB: prec = 3'd1;
         C_MUL, C_DIV: prec = 3'd2;
         C_POW:        prec = 3'd3;
         C_LP, C_RP:   prec = 3'd0;
         default:      prec = P_FN;
      endcase
   endfunction

   assign w_top_idx     = SIW'(r_sp - SPW'(1));
   assign w_top         = r_stack[w_top_idx];
   assign w_top_code    = w_top[7:0];
   assign w_in_code     = inData[7:0];
   assign w_top_prec    = prec(w_top_code);
   assign w_in_prec     = prec(w_in_code);
   assign w_stack_empty = (r_sp == '0);
   assign w_stack_full  = (r_sp == SPW'(stackDepth));
   assign w_start_acc   = (r_state == S_IDLE) && start;

   // Next state and one datapath action per cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      w_pop       = 1'b0;
      w_emit_in   = 1'b0;
      w_emit_top  = 1'b0;
      w_adv       = 1'b0;
      w_fn_set    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) w_state_nxt = S_SCAN;
         end
         S_SCAN: begin
            if (r_count > aw'(depth)) begin
               w_state_nxt = S_ERR;
            end else if (r_fn_pend && !w_stack_empty && w_top_prec == P_FN) begin
               w_pop      = 1'b1;
               w_emit_top = 1'b1;
            end else if (r_idx == r_count) begin
               // Input exhausted: this cycle already performs the first flush step.
               w_state_nxt = S_FLUSH;
               if (w_stack_empty) begin
                  w_state_nxt = S_DONE;
               end else if (w_top_code == C_LP) begin
                  w_state_nxt = S_ERR;
               end else begin
                  w_pop      = 1'b1;
                  w_emit_top = 1'b1;
               end
            end else if (!inData[newWidth-1]) begin
               w_emit_in = 1'b1;
               w_adv     = 1'b1;
            end else if (w_in_code == C_RP) begin
               if (w_stack_empty) begin
                  w_state_nxt = S_ERR;
               end else if (w_top_code == C_LP) begin
                  w_pop    = 1'b1;
                  w_adv    = 1'b1;
                  w_fn_set = 1'b1;
               end else begin
                  w_pop      = 1'b1;
                  w_emit_top = 1'b1;
               end
            end else if (w_in_code != C_LP && w_in_prec != P_FN && !w_stack_empty &&
                         w_top_code != C_LP &&
                         (w_top_prec > w_in_prec ||
                          (w_top_prec == w_in_prec && w_in_code != C_POW))) begin
               w_pop      = 1'b1;
               w_emit_top = 1'b1;
            end else if (w_stack_full) begin
               w_state_nxt = S_ERR;
            end else begin
               w_push = 1'b1;
               w_adv  = 1'b1;
            end
         end
         S_FLUSH: begin
            if (w_stack_empty) begin
               w_state_nxt = S_DONE;
            end else if (w_top_code == C_LP) begin
               w_state_nxt = S_ERR;
            end else begin
               w_pop      = 1'b1;
               w_emit_top = 1'b1;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         S_ERR:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Control, pointers and registered output port.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_sp        <= '0;
         r_idx       <= '0;
         r_count     <= '0;
         r_fn_pend   <= 1'b0;
         r_we        <= 1'b0;
         r_out_addr  <= '0;
         r_out_data  <= '0;
         r_out_count <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_fn_pend <= w_fn_set;
         r_we      <= w_emit_in | w_emit_top;
         if (w_emit_in || w_emit_top) begin
            r_out_addr  <= r_out_count;
            r_out_data  <= w_emit_in ? inData : w_top;
            r_out_count <= r_out_count + aw'(1);
         end
         if (w_push) begin
            r_sp <= r_sp + SPW'(1);
         end else if (w_pop) begin
            r_sp <= r_sp - SPW'(1);
         end
         if (w_adv) r_idx <= r_idx + aw'(1);
         if (w_start_acc) begin
            r_sp        <= '0;
            r_idx       <= '0;
            r_count     <= inCount;
            r_out_count <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
         end
         if (r_state != S_DONE && r_state != S_ERR &&
             (w_state_nxt == S_DONE || w_state_nxt == S_ERR)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_error <= (w_state_nxt == S_ERR);
         end
      end
   end

   // Operator stack storage; validity is tracked solely by r_sp.
   always_ff @(posedge clock) begin
      if (w_push) r_stack[SIW'(r_sp)] <= inData;
   end

   assign inAddr   = r_idx;
   assign outWe    = r_we;
   assign outAddr  = r_out_addr;
   assign outData  = r_out_data;
   assign outCount = r_out_count;
   assign busy     = r_busy;
   assign done     = r_done;
   assign error    = r_error;

endmodule
